// File: rtl/collision_scheduler.sv
// collision_scheduler: time-multiplexed projectile/enemy hit detection, alive flags, score, round clear.
// Revision 1.0
`default_nettype none

module collision_scheduler #(
   parameter int N_ENEMY    = 4,
   parameter int HIT_RADIUS = 25
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_start,
   input  logic                   i_frame_tick,
   input  logic [10*N_ENEMY-1:0]  i_enemy_h,
   input  logic [10*N_ENEMY-1:0]  i_enemy_v,
   input  logic [9:0]             i_proj_h,
   input  logic [9:0]             i_proj_v,
   input  logic                   i_proj_valid,
   output logic [N_ENEMY-1:0]     o_alive,
   output logic                   o_hit_pulse,
   output logic [2:0]             o_hit_idx,
   output logic                   o_proj_consume,
   output logic [7:0]             o_score,
   output logic                   o_round_clear,
   output logic                   o_busy
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_WAIT   = 2'd1;
   localparam logic [1:0] c_SCAN   = 2'd2;
   localparam logic [1:0] c_REPORT = 2'd3;

   localparam logic [10:0]        c_RADIUS    = 11'(HIT_RADIUS);
   localparam logic [N_ENEMY-1:0] c_ALL_ALIVE = '1;
   localparam logic [N_ENEMY-1:0] c_ONE       = {{(N_ENEMY-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [N_ENEMY-1:0] r_alive;
   logic [7:0]         r_score;
   logic               r_round_clear;
   logic [2:0]         r_hit_idx;
   logic [2:0]         r_slot;
   logic [9:0]         r_snap_h;
   logic [9:0]         r_snap_v;

   logic [9:0]         w_eh;
   logic [9:0]         w_ev;
   logic               w_slot_alive;
   logic               w_hit;
   logic               w_last_slot;
   logic               w_scan_go;
   logic [N_ENEMY-1:0] w_alive_cleared;

   // Subtract smaller from larger in 11 bits so distances never wrap.
   function automatic logic [10:0] absdiff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
   endfunction

   always_comb begin
      w_eh         = '0;
      w_ev         = '0;
      w_slot_alive = 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if (r_slot == 3'(i)) begin
            w_eh         = i_enemy_h[i*10 +: 10];
            w_ev         = i_enemy_v[i*10 +: 10];
            w_slot_alive = r_alive[i];
         end
      end
   end

   assign w_hit           = w_slot_alive
                          && (absdiff(r_snap_h, w_eh) <= c_RADIUS)
                          && (absdiff(r_snap_v, w_ev) <= c_RADIUS);
   assign w_last_slot     = (r_slot == 3'(N_ENEMY - 1));
   assign w_scan_go       = i_frame_tick && i_proj_valid && (r_alive != '0);
   assign w_alive_cleared = r_alive & ~(c_ONE << r_hit_idx);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= c_IDLE;
      else            r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (i_start) begin
         w_next_state = c_WAIT;
      end else begin
         case (r_state)
            c_IDLE:   w_next_state = c_IDLE;
            c_WAIT:   if (w_scan_go) w_next_state = c_SCAN;
            c_SCAN: begin
               if (w_hit)            w_next_state = c_REPORT;
               else if (w_last_slot) w_next_state = c_WAIT;
            end
            c_REPORT: w_next_state = (w_alive_cleared == '0) ? c_IDLE : c_WAIT;
            default:  w_next_state = c_IDLE;
         endcase
      end
   end

   always_comb begin
      o_hit_pulse    = (r_state == c_REPORT);
      o_proj_consume = (r_state == c_REPORT);
      o_busy         = (r_state == c_SCAN) || (r_state == c_REPORT);
   end

   // Start overrides everything, so an in-flight report is discarded.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_alive       <= '0;
         r_score       <= '0;
         r_round_clear <= 1'b0;
         r_hit_idx     <= '0;
         r_slot        <= '0;
         r_snap_h      <= '0;
         r_snap_v      <= '0;
      end else if (i_start) begin
         r_alive       <= c_ALL_ALIVE;
         r_score       <= '0;
         r_round_clear <= 1'b0;
      end else begin
         case (r_state)
            c_WAIT: begin
               if (w_scan_go) begin
                  r_snap_h <= i_proj_h;
                  r_snap_v <= i_proj_v;
                  r_slot   <= '0;
               end
            end
            c_SCAN: begin
               if (w_hit)             r_hit_idx <= r_slot;
               else if (!w_last_slot) r_slot    <= r_slot + 3'd1;
            end
            c_REPORT: begin
               r_alive <= w_alive_cleared;
               if (r_score != 8'hFF) r_score <= r_score + 8'd1;
               if (w_alive_cleared == '0) r_round_clear <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_alive       = r_alive;
   assign o_score       = r_score;
   assign o_round_clear = r_round_clear;
   assign o_hit_idx     = r_hit_idx;

endmodule

`default_nettype wire
